// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal processing-element NIC.
// Packets use big-endian bit numbering [0:63]; bit 0 is the VC bit.
package cardinal_nic_pkg;

  localparam int PKT_W  = 64;
  localparam int VC_BIT = 0;

  localparam logic [1:0] ADDR_IBUF  = 2'b00;
  localparam logic [1:0] ADDR_ISTAT = 2'b01;
  localparam logic [1:0] ADDR_OBUF  = 2'b10;
  localparam logic [1:0] ADDR_OSTAT = 2'b11;

  function automatic logic [0:PKT_W-1] status_word(input logic full);
    status_word = {{(PKT_W-1){1'b0}}, full};
  endfunction

endpackage

// File: rtl/nic_out_chan.sv
// Output channel toward the router: one register, or a 2-entry FIFO
// when NIC_OUT_DEPTH2_EN is defined.
module nic_out_chan
  import cardinal_nic_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [0:PKT_W-1] din,
  input  logic             ro,
  input  logic             polarity,
  output logic             full,
  output logic             so,
  output logic [0:PKT_W-1] dout
);

`ifdef NIC_OUT_DEPTH2_EN
  logic [0:PKT_W-1] mem [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic             push;
  logic [0:PKT_W-1] head_pkt;

  assign head_pkt = mem[head];
  assign full     = (count == 2'd2);
  assign push     = wr && !full;
  assign so       = (count != 2'd0) && ro
                    && (polarity == head_pkt[VC_BIT]);
  assign dout     = so ? head_pkt : '0;

  // FIFO pointers and count; full-check uses pre-edge occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= din;
        tail      <= ~tail;
      end
      if (so)
        head <= ~head;
      count <= count + {1'b0, push} - {1'b0, so};
    end
  end
`else
  logic             valid;
  logic [0:PKT_W-1] data;

  assign full = valid;
  assign so   = valid && ro && (polarity == data[VC_BIT]);
  assign dout = so ? data : '0;

  // Single holding register; write only accepted when empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (so) begin
      valid <= 1'b0;
    end else if (wr && !valid) begin
      valid <= 1'b1;
      data  <= din;
    end
  end
`endif

endmodule

// File: rtl/cardinal_pe_nic.sv
// Processor-side NIC for the cardinal router; input side inline,
// output side in nic_out_chan (depth set by NIC_OUT_DEPTH2_EN).
module cardinal_pe_nic
  import cardinal_nic_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [0:1]       addr,
  input  logic [0:PKT_W-1] d_in,
  output logic [0:PKT_W-1] d_out,
  input  logic             nicEn,
  input  logic             nicWrEn,
  input  logic             net_si,
  output logic             net_ri,
  input  logic [0:PKT_W-1] net_di,
  output logic             net_so,
  input  logic             net_ro,
  output logic [0:PKT_W-1] net_do,
  input  logic             net_polarity
);

  logic             in_full;
  logic [0:PKT_W-1] in_buf;
  logic             out_full;
  logic             in_rd;
  logic             out_wr;

  assign in_rd  = nicEn && !nicWrEn && (addr == ADDR_IBUF);
  assign out_wr = nicEn && nicWrEn && (addr == ADDR_OBUF);
  assign net_ri = ~in_full;

  // Input buffer: processor read clears, which beats a new capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_full <= 1'b0;
      in_buf  <= '0;
    end else if (in_rd && in_full) begin
      in_full <= 1'b0;
    end else if (net_si && !in_full) begin
      in_full <= 1'b1;
      in_buf  <= net_di;
    end
  end

  // Processor read mux; zero for writes, idle and the write-only slot
  always_comb begin
    d_out = '0;
    if (nicEn && !nicWrEn) begin
      case (addr)
        ADDR_IBUF:  d_out = in_buf;
        ADDR_ISTAT: d_out = status_word(in_full);
        ADDR_OSTAT: d_out = status_word(out_full);
        default:    d_out = '0;
      endcase
    end
  end

  nic_out_chan u_out (
    .clk      (clk),
    .reset    (reset),
    .wr       (out_wr),
    .din      (d_in),
    .ro       (net_ro),
    .polarity (net_polarity),
    .full     (out_full),
    .so       (net_so),
    .dout     (net_do)
  );

endmodule

// File: tb/tb_cardinal_pe_nic.sv
// Self-checking bench for cardinal_pe_nic: directed cases plus
// randomized traffic against a queue-based model.
module tb_cardinal_pe_nic;

`ifdef NIC_OUT_DEPTH2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  int errs = 0;
  int checks = 0;

  bit          m_in_full;
  logic [63:0] m_in_buf;
  logic [63:0] q[$];

  cardinal_pe_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_in_full = 1'b0;
    m_in_buf  = '0;
    q.delete();
  endfunction

  // Packet MSB (big-endian bit 0) is the VC bit
  function automatic bit exp_so();
    return q.size() > 0 && net_ro && (net_polarity == q[0][63]);
  endfunction

  function automatic logic [63:0] exp_dout();
    if (!nicEn || nicWrEn) return '0;
    case (addr)
      2'b00:   return m_in_buf;
      2'b01:   return {63'b0, m_in_full};
      2'b11:   return {63'b0, q.size() == DEPTH};
      default: return '0;
    endcase
  endfunction

  task automatic compare();
    chk("net_ri", {63'b0, net_ri}, {63'b0, !m_in_full});
    chk("net_so", {63'b0, net_so}, {63'b0, exp_so()});
    chk("net_do", net_do, exp_so() ? q[0] : 64'h0);
    chk("d_out", d_out, exp_dout());
  endtask

  function automatic void update();
    bit wr_ok;
    bit so_now;
    if (reset) return;
    so_now = exp_so();
    wr_ok  = nicEn && nicWrEn && addr == 2'b10 && q.size() < DEPTH;
    if (so_now) void'(q.pop_front());
    if (wr_ok) q.push_back(d_in);
    if (nicEn && !nicWrEn && addr == 2'b00 && m_in_full)
      m_in_full = 1'b0;
    else if (net_si && !m_in_full) begin
      m_in_full = 1'b1;
      m_in_buf  = net_di;
    end
  endfunction

  task automatic cyc_nd();
    compare();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic cyc();
    #2;
    cyc_nd();
  endtask

  task automatic idle();
    nicEn = 0; nicWrEn = 0; addr = 0; d_in = 0;
    net_si = 0; net_di = 0; net_ro = 0; net_polarity = 0;
  endtask

  task automatic rd(input logic [1:0] a);
    nicEn = 1; nicWrEn = 0; addr = a;
  endtask

  task automatic wr(input logic [63:0] d);
    nicEn = 1; nicWrEn = 1; addr = 2'b10; d_in = d;
  endtask

  initial begin
    idle();
    reset = 1;
    model_clear();
    @(negedge clk);
    #1;
    chk("rst_ri", {63'b0, net_ri}, 64'h1);
    chk("rst_so", {63'b0, net_so}, 64'h0);
    cyc_nd();
    reset = 0;
    cyc();

    // capture then read back through status and buffer
    net_si = 1; net_di = 64'h8000_0000_0000_00AA;
    cyc();
    idle();
    rd(2'b01);
    #2;
    chk("ri_after_cap", {63'b0, net_ri}, 64'h0);
    chk("istat_full", d_out, 64'h1);
    cyc_nd();
    rd(2'b00);
    #2;
    chk("ibuf_data", d_out, 64'h8000_0000_0000_00AA);
    cyc_nd();
    rd(2'b01);
    #2;
    chk("istat_empty", d_out, 64'h0);
    cyc_nd();

    // a second strobe while full must not overwrite
    idle();
    net_si = 1; net_di = 64'h1234;
    cyc();
    net_di = 64'hFF;
    cyc();
    idle();
    rd(2'b00);
    #2;
    chk("ibuf_held", d_out, 64'h1234);
    cyc_nd();

    // injection waits for matching polarity
    idle();
    wr(64'h55);
    cyc();
    idle();
    net_ro = 1; net_polarity = 1;
    #2;
    chk("so_wrong_pol", {63'b0, net_so}, 64'h0);
    cyc_nd();
    net_polarity = 0;
    #2;
    chk("so_match", {63'b0, net_so}, 64'h1);
    chk("do_match", net_do, 64'h55);
    cyc_nd();
    rd(2'b11);
    #2;
    chk("ostat_after", d_out, 64'h0);
    chk("so_after", {63'b0, net_so}, 64'h0);
    cyc_nd();

    // back-to-back writes while router stalls
    idle();
    wr(64'h11);
    cyc();
    wr(64'h22);
    cyc();
    idle();
    rd(2'b11);
    #2;
    chk("ostat_2wr", d_out, 64'h1);
    cyc_nd();
    idle();
    net_ro = 1;
    #2;
    chk("so_first", {63'b0, net_so}, 64'h1);
    chk("do_first", net_do, 64'h11);
    cyc_nd();
    #2;
`ifdef NIC_OUT_DEPTH2_EN
    chk("so_second", {63'b0, net_so}, 64'h1);
    chk("do_second", net_do, 64'h22);
`else
    chk("so_dropped", {63'b0, net_so}, 64'h0);
`endif
    cyc_nd();
    cyc();

    // async reset with both channels full and an injection pending
    idle();
    net_si = 1; net_di = 64'hABCD;
    wr(64'h77);
    cyc();
    idle();
    net_ro = 1;
    #1;
    chk("so_pre_rst", {63'b0, net_so}, 64'h1);
    reset = 1;
    model_clear();
    #1;
    chk("ri_in_rst", {63'b0, net_ri}, 64'h1);
    chk("so_in_rst", {63'b0, net_so}, 64'h0);
    rd(2'b01);
    #1;
    chk("istat_rst", d_out, 64'h0);
    addr = 2'b11;
    #1;
    chk("ostat_rst", d_out, 64'h0);
    cyc_nd();
    reset = 0;
    idle();
    net_ro = 1;
    for (int i = 0; i < 4; i++) begin
      net_polarity = i[0];
      #2;
      chk("no_so_post_rst", {63'b0, net_so}, 64'h0);
      cyc_nd();
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 299) == 0);
      nicEn   = ($urandom_range(0, 3) != 0);
      nicWrEn = $urandom_range(0, 1);
      addr    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) addr = 2'b10;
      d_in    = {$urandom, $urandom};
      net_si  = $urandom_range(0, 1);
      net_di  = {$urandom, $urandom};
      net_ro  = $urandom_range(0, 1);
      net_polarity = $urandom_range(0, 1);
      if (reset) model_clear();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cardinal_pe_nic.md
CARDINAL_PE_NIC -- requirements
Module: cardinal_pe_nic

Interface
REQ-001 SHALL use the ports below: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- addr  in  2  processor register select (bit [0:1] ordering)
- d_in  in  64  processor write data
- d_out  out  64  processor read data, combinational
- nicEn  in  1  processor access enable
- nicWrEn  in  1  1 = write, 0 = read (valid with nicEn)
- net_si  in  1  router send-in strobe
- net_ri  out  1  ready to router (input buffer not full)
- net_di  in  64  router packet in
- net_so  out  1  send-out strobe to router
- net_ro  in  1  router ready for injection
- net_do  out  64  packet out to router
- net_polarity  in  1  router even/odd cycle indicator

Function
REQ-002 Address map SHALL be: 00 input channel buffer (R), 01 input status (R), 10 output channel buffer (W), 11 output status (R).
REQ-003 Status reads SHALL return 63'b0 with the full flag in bit 63; buffer read on addr 00 SHALL return stored packet.
REQ-004 d_out SHALL be 64'b0 when nicEn=0, nicWrEn=1, or addr=10.
REQ-005 net_ri SHALL equal ~in_full, combinational.
REQ-006 net_si=1 with in_full=0 SHALL capture net_di and set in_full at the next edge; net_si while in_full=1 SHALL be ignored.
REQ-007 Read of addr 00 (nicEn=1, nicWrEn=0) SHALL clear in_full at the next edge; read while empty returns stale data, no state change.
REQ-008 Write to addr 10 while out buffer not full SHALL store d_in and mark occupied at the next edge; write while full SHALL be dropped; writes to 00/01/11 SHALL be ignored.
REQ-009 Injection SHALL occur when head entry valid, net_ro=1 and net_polarity == head packet bit 0 (VC bit): net_so=1 and net_do=head for exactly that cycle; entry freed at the next edge.
REQ-010 net_so SHALL be combinational from head-valid, net_ro, net_polarity; net_do SHALL be 64'b0 when net_so=0.
REQ-011 Simultaneous injection and processor write in one cycle SHALL be decided on pre-edge occupancy (write dropped if full before the edge).
REQ-012 Simultaneous net_si capture and addr-00 read while full: clear wins, capture ignored (net_ri was 0).

Reset
REQ-013 Reset SHALL asynchronously clear in_full, all output occupancy, both packet registers to 64'b0; net_ri=1, net_so=0, d_out=0 during reset.
REQ-014 Reset mid-transfer SHALL discard any buffered packet; no net_so after reset release until a new write.

Configuration
REQ-015 NIC_OUT_DEPTH2_EN defined: output channel SHALL be a 2-entry FIFO (head/tail pointers, count 0..2), out status full when count=2, write and injection in same cycle with count=2 still drops write; count=1 write+inject SHALL keep count=1 with new entry at head.
REQ-016 NIC_OUT_DEPTH2_EN undefined: output channel SHALL be a single register, full when occupied.

Structure
REQ-017 Shared package cardinal_nic_pkg SHALL hold address codes (ADDR_IBUF, ADDR_ISTAT, ADDR_OBUF, ADDR_OSTAT), packet width 64, VC bit index 0.
REQ-018 Output channel SHALL be a sub-module nic_out_chan (depth per REQ-015/016); input side stays inline.

Verification
REQ-019 net_si=1, net_di=64'h8000_0000_0000_00AA -> net_ri=0 next cycle; read addr 01 -> 64'h1; read addr 00 -> 64'h8000_0000_0000_00AA; then addr 01 -> 64'h0.
REQ-020 Write addr 10 d_in=64'h0000_0000_0000_0055 (VC=0), net_ro=1, net_polarity=1 -> net_so=0; net_polarity=0 -> net_so=1, net_do=64'h55 one cycle, addr 11 -> 64'h0 after.
REQ-021 Two writes 64'h11 then 64'h22 with net_ro=0 -> depth1: second dropped, only 64'h11 sent; NIC_OUT_DEPTH2_EN: both sent in order, addr 11 = 64'h1 after second write.
REQ-022 net_si=1 held while in_full=1 with net_di=64'hFF -> stored packet unchanged.
REQ-023 Reset asserted mid-cycle with both channels full -> immediately net_ri=1, net_so=0, both status reads 64'h0.
